// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I width codes
// and the funct3 legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores have no unsigned variants, so BU/HU codes are only legal for loads.
    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        logic legal;
        legal = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !we;
            default:          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store lane placement, byte enables, load extraction
// and extension. LSU_MISALIGN_TRAP_EN makes misaligned H/W accesses report an error.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        misaligned,
    output logic [1:0]  aligned_off,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Offsets are always forced to natural alignment; with the trap enabled a
    // misaligned access never reaches the bus, so the forcing is harmless there.
    always_comb begin
        misaligned  = 1'b0;
        aligned_off = off;
        be          = 4'h0;
        lane_wdata  = 32'h0;
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << off;
                lane_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
`ifdef LSU_MISALIGN_TRAP_EN
                misaligned = off[0];
`endif
                aligned_off = {off[1], 1'b0};
                be          = 4'b0011 << aligned_off;
                lane_wdata  = {2{wdata[15:0]}};
            end
            2'b10: begin
`ifdef LSU_MISALIGN_TRAP_EN
                misaligned = |off;
`endif
                aligned_off = 2'b00;
                be          = 4'hF;
                lane_wdata  = wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = rdata >> {aligned_off, 3'b000};
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the memory-access stage and a req/gnt/rvalid data memory.
// Misaligned handling is selected by LSU_MISALIGN_TRAP_EN (see lsu_align).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_SIZE      = 10,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_be,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [31:0]          mem_rdata
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        we_q;
    logic [7:0]  timer;

    logic [2:0]  sel_funct3;
    logic [1:0]  sel_off;
    logic        misaligned;
    logic [1:0]  aligned_off;
    logic [3:0]  be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;
    logic        range_err;
    logic        check_fail;

    // The aligner sees the live request while idle and the latched one afterwards,
    // so a single instance serves both store placement and load extraction.
    assign sel_funct3 = (state == IDLE) ? req_funct3 : funct3_q;
    assign sel_off    = (state == IDLE) ? req_addr[1:0] : off_q;

    assign range_err  = |(req_addr >> (ADDR_SIZE + 2));
    assign check_fail = !is_legal(req_we, req_funct3) || range_err || misaligned;

    lsu_align u_align (
        .funct3      (sel_funct3),
        .off         (sel_off),
        .wdata       (req_wdata),
        .rdata       (mem_rdata),
        .misaligned  (misaligned),
        .aligned_off (aligned_off),
        .be          (be),
        .lane_wdata  (lane_wdata),
        .load_data   (load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            mem_be     <= 4'h0;
            timer      <= 8'h0;
            funct3_q   <= 3'h0;
            off_q      <= 2'h0;
            we_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        funct3_q  <= req_funct3;
                        off_q     <= aligned_off;
                        we_q      <= req_we;
                        if (check_fail) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= req_addr[ADDR_SIZE+1:2];
                            mem_wdata <= req_we ? lane_wdata : 32'h0;
                            mem_be    <= be;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= 32'h0;
                        mem_be    <= 4'h0;
                        if (we_q) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= 32'h0;
                        end else begin
                            state <= WAIT;
                            timer <= 8'h0;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_data;
                    end else if (timer == TIMER_LAST) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'h0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a small responding memory
// plus hand-written timeout and mid-operation reset sequences.
module tb_load_store_unit;

    localparam int ADDR_SIZE = 10;
    localparam int TIMEOUT   = 255;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [2:0]           req_funct3;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic                 resp_valid;
    logic [31:0]          resp_rdata;
    logic                 resp_err;
    logic                 mem_req;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [31:0]          mem_wdata;
    logic [3:0]           mem_be;
    logic                 mem_gnt;
    logic                 mem_rvalid;
    logic [31:0]          mem_rdata;

    int num_checks = 0;
    int num_fail   = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gnt_delay;
        int          rv_delay;
        logic [31:0] rdata;
        logic        exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [9:0]  exp_maddr;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        got;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic        saw_req;
        logic [9:0]  maddr;
        logic        mwe;
        logic [3:0]  mbe;
        logic [31:0] mwdata;
        logic        ready_busy;
        logic        pulse_after;
        logic        ready_after;
    } obs_t;

    vec_t vecs[$];

    load_store_unit #(.ADDR_SIZE(ADDR_SIZE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input int gnt_delay, input int rv_delay,
                                   input logic [31:0] rdata, input logic exp_req, input logic [3:0] exp_be,
                                   input logic [31:0] exp_wdata, input logic [9:0] exp_maddr,
                                   input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.gnt_delay = gnt_delay; v.rv_delay = rv_delay; v.rdata = rdata;
        v.exp_req = exp_req; v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_maddr = exp_maddr;
        v.exp_lat = exp_lat; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    // Presents one request, plays memory (gnt after gnt_delay request cycles, rvalid
    // rv_delay cycles after gnt, never if rv_delay is 0) and records what happened.
    task automatic applyStimulus(input vec_t v, output obs_t o);
        int req_cycles;
        int gnt_edge;
        o = '{default: '0};
        req_cycles = 0;
        gnt_edge   = -1;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (cyc == 1) o.ready_busy = req_ready;
            if (resp_valid) begin
                o.got   = 1'b1;
                o.lat   = cyc;
                o.rdata = resp_rdata;
                o.err   = resp_err;
                break;
            end
            if (mem_req) begin
                if (!o.saw_req) begin
                    o.maddr  = mem_addr;
                    o.mwe    = mem_we;
                    o.mbe    = mem_be;
                    o.mwdata = mem_wdata;
                end
                o.saw_req = 1'b1;
                req_cycles++;
                if (req_cycles > v.gnt_delay) begin
                    mem_gnt  = 1'b1;
                    gnt_edge = cyc + 1;
                end
            end
            if (!v.we && v.rv_delay > 0 && gnt_edge > 0 && cyc + 1 == gnt_edge + v.rv_delay) begin
                mem_rvalid = 1'b1;
                mem_rdata  = v.rdata;
            end
        end
        if (o.got) begin
            @(negedge clk);
            o.pulse_after = resp_valid;
            o.ready_after = req_ready;
        end
    endtask

    task automatic runVec(input vec_t v, input int id);
        obs_t o;
        string p;
        p = $sformatf("v%0d", id);
        applyStimulus(v, o);
        checkOutput({p, ".got_resp"}, o.got, 1'b1);
        checkOutput({p, ".latency"}, o.lat, v.exp_lat);
        checkOutput({p, ".resp_err"}, o.err, v.exp_err);
        checkOutput({p, ".resp_rdata"}, o.rdata, v.exp_rdata);
        checkOutput({p, ".bus_access"}, o.saw_req, v.exp_req);
        checkOutput({p, ".ready_busy"}, o.ready_busy, 1'b0);
        checkOutput({p, ".pulse_once"}, o.pulse_after, 1'b0);
        checkOutput({p, ".ready_after"}, o.ready_after, 1'b1);
        if (v.exp_req) begin
            checkOutput({p, ".mem_addr"}, o.maddr, v.exp_maddr);
            checkOutput({p, ".mem_we"}, o.mwe, v.we);
            if (v.we) begin
                checkOutput({p, ".mem_be"}, o.mbe, v.exp_be);
                checkOutput({p, ".mem_wdata"}, o.mwdata, v.exp_wdata);
            end
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".req_ready"}, req_ready, 1'b1);
        checkOutput({tag, ".resp_valid"}, resp_valid, 1'b0);
        checkOutput({tag, ".resp_err"}, resp_err, 1'b0);
        checkOutput({tag, ".resp_rdata"}, resp_rdata, 32'h0);
        checkOutput({tag, ".mem_req"}, mem_req, 1'b0);
        checkOutput({tag, ".mem_we"}, mem_we, 1'b0);
        checkOutput({tag, ".mem_be"}, mem_be, 4'h0);
        checkOutput({tag, ".mem_addr"}, mem_addr, 10'h0);
        checkOutput({tag, ".mem_wdata"}, mem_wdata, 32'h0);
    endtask

    // After reset release, memory keeps poking gnt/rvalid; no response may appear.
    task automatic checkNoStrayResponse(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mem_gnt    = 1'b1;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h5A5A5A5A;
            if (resp_valid) seen = 1'b1;
        end
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (resp_valid) seen = 1'b1;
        checkOutput({tag, ".no_resp"}, seen, 1'b0);
    endtask

    initial begin
        vec_t tv;
        obs_t to;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'h0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        //           we    f3      addr          wdata         g  rv rdata         req be       ewdata        maddr  lat erdata        err
        vecs.push_back(mkVec(1'b1, 3'b000, 32'h0000_0005, 32'hAABBCCDD, 0, 0, 32'h0,        1, 4'b0010, 32'hDDDDDDDD, 10'h001, 2, 32'h0,        0));
        vecs.push_back(mkVec(1'b1, 3'b001, 32'h0000_000A, 32'h12345678, 2, 0, 32'h0,        1, 4'b1100, 32'h56785678, 10'h002, 4, 32'h0,        0));
        vecs.push_back(mkVec(1'b1, 3'b010, 32'h0000_03FC, 32'hCAFEF00D, 1, 0, 32'h0,        1, 4'b1111, 32'hCAFEF00D, 10'h0FF, 3, 32'h0,        0));
        vecs.push_back(mkVec(1'b0, 3'b000, 32'h0000_0007, 32'h0,        0, 3, 32'h80112233, 1, 4'h0,    32'h0,        10'h001, 5, 32'hFFFFFF80, 0));
        vecs.push_back(mkVec(1'b0, 3'b100, 32'h0000_0007, 32'h0,        0, 3, 32'h80112233, 1, 4'h0,    32'h0,        10'h001, 5, 32'h00000080, 0));
        vecs.push_back(mkVec(1'b0, 3'b001, 32'h0000_0006, 32'h0,        0, 1, 32'h80112233, 1, 4'h0,    32'h0,        10'h001, 3, 32'hFFFF8011, 0));
        vecs.push_back(mkVec(1'b0, 3'b101, 32'h0000_0002, 32'h0,        0, 2, 32'hFEDC1234, 1, 4'h0,    32'h0,        10'h000, 4, 32'h0000FEDC, 0));
        vecs.push_back(mkVec(1'b0, 3'b010, 32'h0000_0010, 32'h0,        1, 1, 32'h13579BDF, 1, 4'h0,    32'h0,        10'h004, 4, 32'h13579BDF, 0));
        vecs.push_back(mkVec(1'b0, 3'b000, 32'h0000_0004, 32'h0,        0, 1, 32'h0000007F, 1, 4'h0,    32'h0,        10'h001, 3, 32'h0000007F, 0));
        vecs.push_back(mkVec(1'b0, 3'b010, 32'h0000_0FFC, 32'h0,        0, 1, 32'h0BADF00D, 1, 4'h0,    32'h0,        10'h3FF, 3, 32'h0BADF00D, 0));
        vecs.push_back(mkVec(1'b0, 3'b010, 32'h0000_1000, 32'h0,        0, 1, 32'h11111111, 0, 4'h0,    32'h0,        10'h000, 1, 32'h0,        1));
        vecs.push_back(mkVec(1'b1, 3'b010, 32'h8000_0000, 32'h1,        0, 0, 32'h0,        0, 4'h0,    32'h0,        10'h000, 1, 32'h0,        1));
        vecs.push_back(mkVec(1'b0, 3'b011, 32'h0000_0000, 32'h0,        0, 1, 32'h22222222, 0, 4'h0,    32'h0,        10'h000, 1, 32'h0,        1));
        vecs.push_back(mkVec(1'b1, 3'b100, 32'h0000_0000, 32'hFF,       0, 0, 32'h0,        0, 4'h0,    32'h0,        10'h000, 1, 32'h0,        1));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mkVec(1'b0, 3'b010, 32'h0000_0002, 32'h0,        0, 1, 32'hDEADBEEF, 0, 4'h0,    32'h0,        10'h000, 1, 32'h0,        1));
        vecs.push_back(mkVec(1'b1, 3'b001, 32'h0000_0003, 32'h0000ABCD, 0, 0, 32'h0,        0, 4'h0,    32'h0,        10'h000, 1, 32'h0,        1));
`else
        vecs.push_back(mkVec(1'b0, 3'b010, 32'h0000_0002, 32'h0,        0, 1, 32'hDEADBEEF, 1, 4'h0,    32'h0,        10'h000, 3, 32'hDEADBEEF, 0));
        vecs.push_back(mkVec(1'b1, 3'b001, 32'h0000_0003, 32'h0000ABCD, 0, 0, 32'h0,        1, 4'b1100, 32'hABCDABCD, 10'h000, 2, 32'h0,        0));
`endif

        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b1;

        foreach (vecs[i]) runVec(vecs[i], i);

        // Load with no read data: aborted exactly TIMEOUT cycles after gnt (gnt edge is 2).
        runVec(mkVec(1'b0, 3'b010, 32'h0000_0020, 32'h0, 0, 0, 32'h77777777,
                     1, 4'h0, 32'h0, 10'h008, 2 + TIMEOUT, 32'h0, 1), 100);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h77777777;
        @(negedge clk);
        mem_rvalid = 1'b0;
        checkOutput("late_rvalid.resp_valid", resp_valid, 1'b0);
        checkOutput("late_rvalid.req_ready", req_ready, 1'b1);
        runVec(vecs[0], 101);

        // Reset while the bus request is outstanding.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'h1;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rst_req.mem_req_before", mem_req, 1'b1);
        #2 rst = 1'b0;
        #1 checkResetValues("rst_req");
        @(negedge clk);
        rst = 1'b1;
        checkNoStrayResponse("rst_req");

        // Reset while waiting for read data.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h80; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        mem_gnt   = mem_req;
        @(negedge clk);
        mem_gnt = 1'b0;
        checkOutput("rst_wait.req_ready_before", req_ready, 1'b0);
        #2 rst = 1'b0;
        #1 checkResetValues("rst_wait");
        @(negedge clk);
        rst = 1'b1;
        checkNoStrayResponse("rst_wait");
        tv = vecs[3];
        applyStimulus(tv, to);
        checkOutput("post_rst.got_resp", to.got, 1'b1);
        checkOutput("post_rst.resp_rdata", to.rdata, 32'hFFFFFF80);
        checkOutput("post_rst.latency", to.lat, 5);

        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fail);
        $finish;
    end

endmodule
